// File: rtl/apb_bridge_pkg.sv
// Shared completion codes and FSM state type for the low-frequency APB master.
package apb_bridge_pkg;

  localparam logic [1:0] RESP_OKAY    = 2'd0;
  localparam logic [1:0] RESP_SLVERR  = 2'd1;
  localparam logic [1:0] RESP_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_toggle_sync.sv
// Toggle-to-pulse synchroniser: SYNC_STAGES flops plus a history flop.
module apb_toggle_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tog_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse_o = sync_q[SYNC_STAGES-1] ^ hist_q;

endmodule

// File: rtl/low_frequency_apb_master.sv
// APB master driven by a toggle request from a slower source domain.
// Optional ACCESS timeout enabled by LOW_FREQUENCY_APB_MASTER_TIMEOUT_EN.
module low_frequency_apb_master
  import apb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WD        = 32,
  parameter int unsigned DATA_WD        = 32,
  parameter int unsigned STRB_WD        = DATA_WD / 8,
  parameter int unsigned PROT_WD        = 3,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic               b_pclk,
  input  logic               b_prst,
  input  logic               a_apb_req,
  input  logic               write,
  input  logic [ADDR_WD-1:0] addr,
  input  logic [DATA_WD-1:0] wdata,
  input  logic [PROT_WD-1:0] prot,
  input  logic [STRB_WD-1:0] strb,
  output logic               b_psel,
  output logic               b_penable,
  output logic               b_pwrite,
  output logic [ADDR_WD-1:0] b_paddr,
  output logic [DATA_WD-1:0] b_pwdata,
  output logic [PROT_WD-1:0] b_pprot,
  output logic [STRB_WD-1:0] b_pstrb,
  input  logic [DATA_WD-1:0] b_prdata,
  input  logic               b_pready,
  input  logic               b_pslverr,
  output logic               b_ready_req,
  output logic [DATA_WD-1:0] rdata,
  output logic [1:0]         resp,
  output logic               b_req_ovf
);

  apb_state_e         state_q, state_d;
  logic               req_edge;
  logic               timeout;
  logic               done_ok;

  logic               pwrite_q;
  logic [ADDR_WD-1:0] paddr_q;
  logic [DATA_WD-1:0] pwdata_q;
  logic [PROT_WD-1:0] pprot_q;
  logic [STRB_WD-1:0] pstrb_q;
  logic               ack_q;
  logic [DATA_WD-1:0] rdata_q;
  logic [1:0]         resp_q;
  logic               ovf_q;

  apb_toggle_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk_i  (b_pclk),
    .rst_i  (b_prst),
    .tog_i  (a_apb_req),
    .pulse_o(req_edge)
  );

  assign done_ok = (state_q == ST_ACCESS) && b_pready;

`ifdef LOW_FREQUENCY_APB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_WD = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_WD-1:0] cnt_q;

  // cnt_q counts earlier stalled ACCESS cycles, so the limit fires on the last allowed one
  always_ff @(posedge b_pclk or posedge b_prst) begin
    if (b_prst) begin
      cnt_q <= '0;
    end else if (state_q != ST_ACCESS) begin
      cnt_q <= '0;
    end else if (!b_pready && (cnt_q != CNT_WD'(TIMEOUT_CYCLES))) begin
      cnt_q <= cnt_q + CNT_WD'(1);
    end
  end

  assign timeout = (state_q == ST_ACCESS) && !b_pready &&
                   (cnt_q >= CNT_WD'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^{(TIMEOUT_CYCLES != 0), RESP_TIMEOUT};
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge b_pclk or posedge b_prst) begin
    if (b_prst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (req_edge) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (done_ok || timeout) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    b_psel    = (state_q != ST_IDLE);
    b_penable = (state_q == ST_ACCESS);
  end

  always_ff @(posedge b_pclk or posedge b_prst) begin
    if (b_prst) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pprot_q  <= '0;
      pstrb_q  <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      resp_q   <= RESP_OKAY;
      ovf_q    <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && req_edge) begin
        pwrite_q <= write;
        paddr_q  <= addr;
        pwdata_q <= wdata;
        pprot_q  <= prot;
        pstrb_q  <= strb;
      end
      if ((state_q != ST_IDLE) && req_edge) begin
        ovf_q <= 1'b1;
      end
      if (done_ok) begin
        ack_q  <= ~ack_q;
        resp_q <= b_pslverr ? RESP_SLVERR : RESP_OKAY;
        if (!pwrite_q) rdata_q <= b_prdata;
      end else if (timeout) begin
`ifdef LOW_FREQUENCY_APB_MASTER_TIMEOUT_EN
        ack_q  <= ~ack_q;
        resp_q <= RESP_TIMEOUT;
        if (!pwrite_q) rdata_q <= '0;
`endif
      end
    end
  end

  assign b_pwrite    = pwrite_q;
  assign b_paddr     = paddr_q;
  assign b_pwdata    = pwdata_q;
  assign b_pprot     = pprot_q;
  assign b_pstrb     = pstrb_q;
  assign b_ready_req = ack_q;
  assign rdata       = rdata_q;
  assign resp        = resp_q;
  assign b_req_ovf   = ovf_q;

endmodule

// File: tb/tb_low_frequency_apb_master.sv
// Bench for low_frequency_apb_master: directed table, corner sequences and random transfers.
module tb_low_frequency_apb_master;

  localparam int SYNC = 3;
  localparam int TO   = 8;
`ifdef LOW_FREQUENCY_APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        b_pclk = 1'b0;
  logic        b_prst;
  logic        a_apb_req, write;
  logic [31:0] addr, wdata, b_prdata;
  logic [2:0]  prot;
  logic [3:0]  strb;
  logic        b_pready, b_pslverr;
  logic        b_psel, b_penable, b_pwrite, b_ready_req, b_req_ovf;
  logic [31:0] b_paddr, b_pwdata, rdata;
  logic [2:0]  b_pprot;
  logic [3:0]  b_pstrb;
  logic [1:0]  resp;

  low_frequency_apb_master #(
    .ADDR_WD(32), .DATA_WD(32), .STRB_WD(4), .PROT_WD(3),
    .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .b_pclk(b_pclk), .b_prst(b_prst), .a_apb_req(a_apb_req),
    .write(write), .addr(addr), .wdata(wdata), .prot(prot), .strb(strb),
    .b_psel(b_psel), .b_penable(b_penable), .b_pwrite(b_pwrite),
    .b_paddr(b_paddr), .b_pwdata(b_pwdata), .b_pprot(b_pprot), .b_pstrb(b_pstrb),
    .b_prdata(b_prdata), .b_pready(b_pready), .b_pslverr(b_pslverr),
    .b_ready_req(b_ready_req), .rdata(rdata), .resp(resp), .b_req_ovf(b_req_ovf)
  );

  always #5 b_pclk = ~b_pclk;

  typedef struct {
    bit          w;
    logic [31:0] addr, wdata, prdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    bit          slverr;
    int          wt;
    int          extra;
    int          exp_acc;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    bit          exp_ovf;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_rdata;
  bit          model_ovf;
  vec_t        tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit w, logic [31:0] a, logic [31:0] wd, logic [31:0] rd,
                              logic [3:0] s, logic [2:0] p, bit se, int wt, int ex,
                              int eacc, logic [1:0] eresp, logic [31:0] erd, bit eovf);
    vec_t v;
    v.w = w; v.addr = a; v.wdata = wd; v.prdata = rd; v.strb = s; v.prot = p;
    v.slverr = se; v.wt = wt; v.extra = ex;
    v.exp_acc = eacc; v.exp_resp = eresp; v.exp_rdata = erd; v.exp_ovf = eovf;
    return v;
  endfunction

  // Reference: a stall of TO or more cycles times out (if enabled), otherwise wt+1 ACCESS cycles
  function automatic vec_t predict(vec_t v);
    bit to;
    to = TO_EN && (v.wt >= TO);
    v.exp_acc   = to ? TO : v.wt + 1;
    v.exp_resp  = to ? 2'd2 : (v.slverr ? 2'd1 : 2'd0);
    v.exp_rdata = v.w ? model_rdata : (to ? 32'h0 : v.prdata);
    v.exp_ovf   = model_ovf;
    return v;
  endfunction

  task automatic run_xfer(input vec_t v, input string tag);
    int   acc, tog, psel_late;
    bit   done;
    logic ack_prev;
    acc = 0; tog = 0; psel_late = 0; done = 1'b0;
    @(posedge b_pclk); #1;
    b_pready = 1'b0; b_pslverr = 1'b0; b_prdata = $urandom;
    write = v.w; addr = v.addr; wdata = v.wdata; prot = v.prot; strb = v.strb;
    ack_prev = b_ready_req;
    a_apb_req = ~a_apb_req;
    for (int k = 1; k <= SYNC + 1; k++) begin
      @(posedge b_pclk); @(negedge b_pclk);
      if (b_ready_req !== ack_prev) begin tog++; ack_prev = b_ready_req; end
      if (k == SYNC) chk({tag, "_lat_lo"}, b_psel, 1'b0);
    end
    chk({tag, "_lat_hi"}, b_psel, 1'b1);
    chk({tag, "_setup_pen"}, b_penable, 1'b0);
    chk({tag, "_setup_bus"}, {b_pwrite, b_paddr, b_pstrb, b_pprot},
        {v.w, v.addr, v.strb, v.prot});
    chk({tag, "_setup_wdata"}, b_pwdata, v.wdata);
    for (int c = 0; c < 2000 && !done; c++) begin
      @(posedge b_pclk); @(negedge b_pclk);
      if (b_ready_req !== ack_prev) begin tog++; ack_prev = b_ready_req; end
      if (b_psel && b_penable) begin
        acc++;
        b_prdata = $urandom;
        if (v.extra == acc) a_apb_req = ~a_apb_req;
        if (v.wt >= 0 && acc == v.wt + 1) begin
          b_pready = 1'b1; b_prdata = v.prdata; b_pslverr = v.slverr;
        end
      end else begin
        done = 1'b1;
      end
    end
    b_pready = 1'b0; b_pslverr = 1'b0;
    chk({tag, "_done_bound"}, done, 1'b1);
    chk({tag, "_acc_cycles"}, acc, v.exp_acc);
    chk({tag, "_resp"}, resp, v.exp_resp);
    chk({tag, "_rdata"}, rdata, v.exp_rdata);
    for (int c = 0; c < SYNC + 3; c++) begin
      @(posedge b_pclk); @(negedge b_pclk);
      if (b_ready_req !== ack_prev) begin tog++; ack_prev = b_ready_req; end
      if (b_psel) psel_late++;
    end
    chk({tag, "_ack_toggles"}, tog, 1);
    chk({tag, "_idle_after"}, psel_late, 0);
    chk({tag, "_ovf"}, b_req_ovf, v.exp_ovf);
    model_rdata = v.exp_rdata;
    model_ovf   = v.exp_ovf;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {b_psel, b_penable, b_pwrite, b_ready_req, b_req_ovf, resp}, '0);
    chk({tag, "_bus"}, {b_paddr, b_pstrb, b_pprot}, '0);
    chk({tag, "_wdata"}, b_pwdata, '0);
    chk({tag, "_rdata"}, rdata, '0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bit   reached;
    b_prst = 1'b1; a_apb_req = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    prot = '0; strb = '0; b_prdata = '0; b_pready = 1'b0; b_pslverr = 1'b0;
    model_rdata = '0; model_ovf = 1'b0;

    tbl[0] = mk(1, 32'h100, 32'hDEADBEEF, 32'h0,        4'hF, 3'd0, 0, 0, 0, 1, 2'd0, 32'h0,        0);
    tbl[1] = mk(0, 32'h200, 32'h0,        32'h12345678, 4'hF, 3'd1, 0, 3, 0, 4, 2'd0, 32'h12345678, 0);
    tbl[2] = mk(0, 32'h300, 32'h0,        32'hA5A5A5A5, 4'h0, 3'd0, 1, 0, 0, 1, 2'd1, 32'hA5A5A5A5, 0);
    tbl[3] = mk(1, 32'h400, 32'h01020304, 32'h0,        4'h3, 3'd2, 1, 2, 0, 3, 2'd1, 32'hA5A5A5A5, 0);
    tbl[4] = mk(0, 32'h500, 32'h0,        32'hCAFEF00D, 4'hF, 3'd0, 0, 7, 0, 8, 2'd0, 32'hCAFEF00D, 0);
    tbl[5] = mk(0, 32'h600, 32'h0,        32'h0BADF00D, 4'hF, 3'd7, 0, 5, 1, 6, 2'd0, 32'h0BADF00D, 1);

    repeat (3) @(posedge b_pclk);
    #1 b_prst = 1'b0;
    @(negedge b_pclk);
    chk_all_zero("reset");

    for (int i = 0; i < 6; i++) run_xfer(tbl[i], $sformatf("tbl%0d", i));

    // Stall past the limit: times out at TO cycles when enabled, else waits 1000 cycles
    v = predict(mk(0, 32'h800, 32'h0, 32'h77778888, 4'hF, 3'd0, 0, 1000, 0, 0, 0, 0, 0));
    run_xfer(v, "long_rd");
    v = predict(mk(0, 32'h804, 32'h0, 32'h11112222, 4'hF, 3'd0, 0, 0, 0, 0, 0, 0, 0));
    run_xfer(v, "refill_rd");
    v = predict(mk(1, 32'h808, 32'h55AA55AA, 32'h0, 4'hF, 3'd0, 1, TO, 0, 0, 0, 0, 0));
    run_xfer(v, "long_wr");

    // Reset in the middle of ACCESS
    @(posedge b_pclk); #1;
    write = 1'b0; addr = 32'h700; strb = 4'hF; a_apb_req = ~a_apb_req;
    reached = 1'b0;
    for (int c = 0; c < 20 && !reached; c++) begin
      @(negedge b_pclk);
      if (b_penable) reached = 1'b1;
    end
    chk("rst_reach_access", reached, 1'b1);
    @(posedge b_pclk); #2;
    b_prst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    a_apb_req = 1'b0;
    repeat (2) @(posedge b_pclk);
    #1 b_prst = 1'b0;
    model_rdata = '0; model_ovf = 1'b0;
    repeat (SYNC + 3) @(negedge b_pclk);
    chk("rst_no_restart", {b_psel, b_ready_req}, 2'b00);
    v = predict(mk(0, 32'h704, 32'h0, 32'h600DCAFE, 4'hF, 3'd0, 0, 1, 0, 0, 0, 0, 0));
    run_xfer(v, "post_rst");

    for (int i = 0; i < 20; i++) begin
      v = mk($urandom_range(0, 1), $urandom, $urandom, $urandom, 4'($urandom), 3'($urandom),
             $urandom_range(0, 1), $urandom_range(0, 11), 0, 0, 0, 0, 0);
      v = predict(v);
      run_xfer(v, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/low_frequency_apb_master.md
LOW_FREQUENCY_APB_MASTER -- requirements
Module: low_frequency_apb_master

Interface
REQ-001 Parameter ADDR_WD, default 32, address width.
REQ-002 Parameter DATA_WD, default 32, data width.
REQ-003 Parameter STRB_WD, default DATA_WD/8, write-strobe width.
REQ-004 Parameter PROT_WD, default 3, protection width.
REQ-005 Parameter SYNC_STAGES, default 2, legal 2..4, request synchroniser depth.
REQ-006 Parameter TIMEOUT_CYCLES, default 256, legal 2..65535, ACCESS-phase cycle limit.
REQ-007 b_pclk  input  1  sole clock; all logic on rising edge.
REQ-008 b_prst  input  1  reset, asynchronous, active-high.
REQ-009 a_apb_req  input  1  request toggle from source domain; each transition is one request.
REQ-010 write, addr, wdata, prot, strb  input  1/ADDR_WD/DATA_WD/PROT_WD/STRB_WD  request payload; source holds it stable from the request toggle until the acknowledge toggle.
REQ-011 b_psel, b_penable, b_pwrite  output  1 each  APB control.
REQ-012 b_paddr, b_pwdata, b_pprot, b_pstrb  output  ADDR_WD/DATA_WD/PROT_WD/STRB_WD  APB payload.
REQ-013 b_prdata  input  DATA_WD; b_pready  input  1; b_pslverr  input  1  APB completer response.
REQ-014 b_ready_req  output  1  acknowledge toggle, one transition per completed request.
REQ-015 rdata  output  DATA_WD  captured read data.
REQ-016 resp  output  2  completion code: 0 OKAY, 1 SLVERR, 2 TIMEOUT; 3 is reserved and never driven.
REQ-017 b_req_ovf  output  1  sticky flag: a request arrived while busy.

Function
REQ-018 a_apb_req SHALL pass through SYNC_STAGES flops plus one history flop; req_edge = last sync stage XOR history flop.
REQ-019 FSM states SHALL be IDLE, SETUP, ACCESS.
REQ-020 IDLE -> SETUP on req_edge; the same edge captures write/addr/wdata/prot/strb into the b_p* registers.
REQ-021 SETUP: b_psel=1, b_penable=0; the FSM SHALL go to ACCESS unconditionally next cycle.
REQ-022 ACCESS: b_psel=1, b_penable=1; exit to IDLE when b_pready=1 or on timeout.
REQ-023 Latency: a toggle of a_apb_req sampled at edge 0 SHALL make b_psel high after edge SYNC_STAGES+1.
REQ-024 ACCESS exit on b_pready SHALL toggle b_ready_req and set resp=b_pslverr?1:0.
REQ-025 On a read exit with b_pready, rdata SHALL capture b_prdata, including when b_pslverr=1. Write completions SHALL leave rdata unchanged.
REQ-026 ACCESS timeout counter:
- cleared on entry to ACCESS; increments each ACCESS cycle with b_pready=0.
- at TIMEOUT_CYCLES it SHALL end the transfer: FSM to IDLE, resp=2, b_ready_req toggles.
- a timed-out read SHALL set rdata to 0.
REQ-027 b_pready=1 in the same cycle the timeout limit is reached SHALL complete normally, not as a timeout.
REQ-028 A req_edge in SETUP or ACCESS SHALL be dropped, set b_req_ovf and leave the current transfer unaffected.
REQ-029 b_req_ovf SHALL clear only on reset.
REQ-030 In IDLE, b_psel=0 and b_penable=0; b_p* payload, rdata and resp SHALL hold their last values.
REQ-031 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1); the counter SHALL saturate and never wrap.

Reset
REQ-032 Asserting b_prst SHALL asynchronously force:
- FSM to IDLE; synchroniser, history flop and counter to 0.
- b_psel, b_penable, b_ready_req, b_req_ovf to 0; resp to 0; rdata to 0; b_p* payload to 0.
REQ-033 Reset during SETUP or ACCESS SHALL abort the transfer with no acknowledge toggle; the source domain is reset together with this block.

Configuration
REQ-034 Macro LOW_FREQUENCY_APB_MASTER_TIMEOUT_EN:
- defined: REQ-026/027/031 apply.
- undefined: no counter is built; ACCESS waits indefinitely for b_pready, and resp is never 2.

Structure
REQ-035 Package apb_bridge_pkg SHALL hold the resp code constants (OKAY, SLVERR, TIMEOUT) and the FSM state enum.
REQ-036 Sub-module apb_toggle_sync (SYNC_STAGES parameter, toggle in, pulse out) SHALL implement REQ-018.

Verification
REQ-037 Write: addr=0x100, wdata=0xDEADBEEF, strb=0xF, b_pready=1 on first ACCESS -> one SETUP then one ACCESS cycle; b_ready_req toggles; resp=0; rdata unchanged.
REQ-038 Read: addr=0x200, b_prdata=0x12345678, b_pready after 3 wait cycles -> rdata=0x12345678, resp=0; ACCESS lasts 4 cycles.
REQ-039 Read with b_pslverr=1, b_prdata=0xA5A5A5A5 -> resp=1, rdata=0xA5A5A5A5, one ack toggle.
REQ-040 TIMEOUT_CYCLES=8, b_pready held 0 -> exit after 8 ACCESS cycles; resp=2; rdata=0; psel low next cycle. With macro undefined -> still in ACCESS after 1000 cycles.
REQ-041 Second a_apb_req toggle during ACCESS -> b_req_ovf=1; exactly one transfer and one ack toggle occur.
REQ-042 b_prst pulsed mid-ACCESS -> all outputs 0 immediately; no ack toggle; next request after reset completes normally.
